// File: rtl/axi_memory_slave_3channels_if.sv
// Bus bundle for the shared memory slave: one write port (AW/W/B) and two
// independent read ports (AR/R and AR_2/R_2). Simplified AXI, no IDs.
interface axi_memory_slave_3channels_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  // write address
  logic [ADDR_WIDTH-1:0] awaddr;
  logic [7:0]            awlen;
  logic                  awvalid;
  logic                  awready;
  // write data
  logic [DATA_WIDTH-1:0] wdata;
  logic                  wlast;
  logic                  wvalid;
  logic                  wready;
  // write response
  logic [1:0]            bresp;
  logic                  bvalid;
  logic                  bready;
  // read port 1
  logic [ADDR_WIDTH-1:0] araddr;
  logic [7:0]            arlen;
  logic                  arvalid;
  logic                  arready;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  rlast;
  logic                  rvalid;
  logic                  rready;
  // read port 2
  logic [ADDR_WIDTH-1:0] araddr_2;
  logic [7:0]            arlen_2;
  logic                  arvalid_2;
  logic                  arready_2;
  logic [DATA_WIDTH-1:0] rdata_2;
  logic                  rlast_2;
  logic                  rvalid_2;
  logic                  rready_2;

  modport slave (
    input  awaddr, awlen, awvalid,
    output awready,
    input  wdata, wlast, wvalid,
    output wready,
    output bresp, bvalid,
    input  bready,
    input  araddr, arlen, arvalid,
    output arready,
    output rdata, rlast, rvalid,
    input  rready,
    input  araddr_2, arlen_2, arvalid_2,
    output arready_2,
    output rdata_2, rlast_2, rvalid_2,
    input  rready_2
  );

  modport master (
    output awaddr, awlen, awvalid,
    input  awready,
    output wdata, wlast, wvalid,
    input  wready,
    input  bresp, bvalid,
    output bready,
    output araddr, arlen, arvalid,
    input  arready,
    input  rdata, rlast, rvalid,
    output rready,
    output araddr_2, arlen_2, arvalid_2,
    input  arready_2,
    input  rdata_2, rlast_2, rvalid_2,
    output rready_2
  );
endinterface

// File: rtl/axi_memory_slave_3channels.sv
// Word-addressed shared memory: one burst write port, two independent burst
// read ports. INCR bursts only, wlast ends a write burst, responses always OKAY.
// Contents are reloaded (zeros or mem[i]=i) on every reset, so the array is
// held in registers rather than a RAM macro.
module axi_memory_slave_3channels #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int ID_WIDTH    = 4,
  parameter int MEM_SIZE    = 32,
  parameter int INIT_OPTION = 1
) (
  input logic clk,
  input logic rst,
  axi_memory_slave_3channels_if.slave bus
);

  localparam int IDX_W = (MEM_SIZE > 1) ? $clog2(MEM_SIZE) : 1;
  typedef logic [IDX_W-1:0] idx_t;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
  typedef enum logic {R_IDLE, R_DATA} r_state_t;

  logic [DATA_WIDTH-1:0] mem [MEM_SIZE];

  // ---------------- write port ----------------
  w_state_t w_state_reg, w_state_next;
  idx_t     wptr_reg;
  logic [7:0] awlen_reg;
  logic     mem_we;

  // write FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) w_state_reg <= W_IDLE;
    else     w_state_reg <= w_state_next;
  end

  // write FSM next state: wlast alone terminates the burst
  always_comb begin
    w_state_next = w_state_reg;
    case (w_state_reg)
      W_IDLE: if (bus.awvalid) w_state_next = W_DATA;
      W_DATA: if (bus.wvalid && bus.wlast) w_state_next = W_RESP;
      W_RESP: if (bus.bready) w_state_next = W_IDLE;
      default: w_state_next = W_IDLE;
    endcase
  end

  // write FSM outputs decoded from registered state only
  always_comb begin
    bus.awready = (w_state_reg == W_IDLE);
    bus.wready  = (w_state_reg == W_DATA);
    bus.bvalid  = (w_state_reg == W_RESP);
    bus.bresp   = 2'b00;
    mem_we      = (w_state_reg == W_DATA) && bus.wvalid;
  end

  // write pointer: loaded on AW, advanced on each accepted beat, wraps naturally
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_reg  <= '0;
      awlen_reg <= '0;
    end else if (w_state_reg == W_IDLE && bus.awvalid) begin
      wptr_reg  <= bus.awaddr[IDX_W-1:0];
      awlen_reg <= bus.awlen;
    end else if (mem_we) begin
      wptr_reg  <= idx_t'(wptr_reg + 1'b1);
    end
  end

  // storage: reload on reset, otherwise one word per accepted write beat
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < MEM_SIZE; i++)
        mem[i] <= (INIT_OPTION == 1) ? DATA_WIDTH'(i) : '0;
    end else if (mem_we) begin
      mem[wptr_reg] <= bus.wdata;
    end
  end

  // ---------------- read ports ----------------
  // Both ports share one implementation; bus signals are mapped to
  // per-port vectors so a generate loop can build the two engines.
  logic [1:0][IDX_W-1:0]      ar_idx;
  logic [1:0][7:0]            ar_len;
  logic [1:0]                 ar_valid;
  logic [1:0]                 ar_ready;
  logic [1:0]                 r_ready;
  logic [1:0]                 r_valid;
  logic [1:0]                 r_last;
  logic [1:0][DATA_WIDTH-1:0] r_data;

  assign ar_idx[0]   = bus.araddr[IDX_W-1:0];
  assign ar_idx[1]   = bus.araddr_2[IDX_W-1:0];
  assign ar_len[0]   = bus.arlen;
  assign ar_len[1]   = bus.arlen_2;
  assign ar_valid[0] = bus.arvalid;
  assign ar_valid[1] = bus.arvalid_2;
  assign r_ready[0]  = bus.rready;
  assign r_ready[1]  = bus.rready_2;

  assign bus.arready   = ar_ready[0];
  assign bus.arready_2 = ar_ready[1];
  assign bus.rvalid    = r_valid[0];
  assign bus.rvalid_2  = r_valid[1];
  assign bus.rlast     = r_last[0];
  assign bus.rlast_2   = r_last[1];
  assign bus.rdata     = r_data[0];
  assign bus.rdata_2   = r_data[1];

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_rd
      r_state_t              state_reg, state_next;
      logic [7:0]            len_reg;
      logic [7:0]            cnt_reg;
      idx_t                  ptr_reg;
      logic [DATA_WIDTH-1:0] rdata_reg;
      logic                  arready_c, rvalid_c, rlast_c;

      // read FSM state register
      always_ff @(posedge clk or posedge rst) begin
        if (rst) state_reg <= R_IDLE;
        else     state_reg <= state_next;
      end

      // read FSM next state: leave after the last beat is taken
      always_comb begin
        state_next = state_reg;
        case (state_reg)
          R_IDLE: if (ar_valid[gi]) state_next = R_DATA;
          R_DATA: if (r_ready[gi] && rlast_c) state_next = R_IDLE;
          default: state_next = R_IDLE;
        endcase
      end

      // read FSM outputs decoded from registered state and beat counter
      always_comb begin
        arready_c = (state_reg == R_IDLE);
        rvalid_c  = (state_reg == R_DATA);
        rlast_c   = (state_reg == R_DATA) && (cnt_reg == len_reg);
      end

      // read datapath: first word fetched with the AR handshake, next word
      // fetched on each accepted non-final beat; holds while rready is low
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          len_reg   <= '0;
          cnt_reg   <= '0;
          ptr_reg   <= '0;
          rdata_reg <= '0;
        end else if (state_reg == R_IDLE && ar_valid[gi]) begin
          len_reg   <= ar_len[gi];
          cnt_reg   <= '0;
          ptr_reg   <= ar_idx[gi];
          rdata_reg <= mem[ar_idx[gi]];
        end else if (state_reg == R_DATA && r_ready[gi] && !rlast_c) begin
          cnt_reg   <= cnt_reg + 8'd1;
          ptr_reg   <= idx_t'(ptr_reg + 1'b1);
          rdata_reg <= mem[idx_t'(ptr_reg + 1'b1)];
        end
      end

      assign ar_ready[gi] = arready_c;
      assign r_valid[gi]  = rvalid_c;
      assign r_last[gi]   = rlast_c;
      assign r_data[gi]   = rdata_reg;
    end
  endgenerate

  // Upper address bits, the write length and the ID width carry no function
  // here; fold them into one sink so they are visibly consumed.
  logic unused_bits;
  assign unused_bits = ^{awlen_reg, bus.awaddr, bus.araddr, bus.araddr_2, 1'(ID_WIDTH)};

endmodule

// File: tb/tb_axi_memory_slave_3channels.sv
// Directed bench for the 3-channel memory slave: inputs are driven on the
// falling edge, outputs are compared on the falling edge before new drives.
module tb_axi_memory_slave_3channels;

  typedef logic [31:0] words_t [8];

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  axi_memory_slave_3channels_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

  axi_memory_slave_3channels #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .ID_WIDTH(4), .MEM_SIZE(32), .INIT_OPTION(1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_compared   = 0;
  int n_mismatched = 0;
  words_t exp_w;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_compared++;
    if (got !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.awaddr = '0; bus.awlen = '0; bus.awvalid = 1'b0;
    bus.wdata = '0; bus.wlast = 1'b0; bus.wvalid = 1'b0; bus.bready = 1'b0;
    bus.araddr = '0; bus.arlen = '0; bus.arvalid = 1'b0; bus.rready = 1'b0;
    bus.araddr_2 = '0; bus.arlen_2 = '0; bus.arvalid_2 = 1'b0; bus.rready_2 = 1'b0;
  endtask

  // Check every output against its reset value.
  task automatic check_reset_outputs(input string pfx);
    check({pfx, " awready"}, 32'(bus.awready), 32'd1);
    check({pfx, " arready"}, 32'(bus.arready), 32'd1);
    check({pfx, " arready_2"}, 32'(bus.arready_2), 32'd1);
    check({pfx, " wready"}, 32'(bus.wready), 32'd0);
    check({pfx, " bvalid"}, 32'(bus.bvalid), 32'd0);
    check({pfx, " bresp"}, 32'(bus.bresp), 32'd0);
    check({pfx, " rvalid"}, 32'(bus.rvalid), 32'd0);
    check({pfx, " rvalid_2"}, 32'(bus.rvalid_2), 32'd0);
    check({pfx, " rlast"}, 32'(bus.rlast), 32'd0);
    check({pfx, " rlast_2"}, 32'(bus.rlast_2), 32'd0);
    check({pfx, " rdata"}, bus.rdata, 32'd0);
    check({pfx, " rdata_2"}, bus.rdata_2, 32'd0);
  endtask

  // Single burst on one read port with rready held high.
  task automatic read_burst(input int port, input int addr, input int len, input words_t exp);
    $display("read  port %0d addr %0d len %0d", port, addr, len);
    @(negedge clk);
    if (port == 1) begin
      check("p1 arready idle", 32'(bus.arready), 32'd1);
      bus.araddr = 32'(addr); bus.arlen = 8'(len); bus.arvalid = 1'b1; bus.rready = 1'b1;
    end else begin
      check("p2 arready idle", 32'(bus.arready_2), 32'd1);
      bus.araddr_2 = 32'(addr); bus.arlen_2 = 8'(len); bus.arvalid_2 = 1'b1; bus.rready_2 = 1'b1;
    end
    @(negedge clk);
    bus.arvalid = 1'b0; bus.arvalid_2 = 1'b0;
    for (int b = 0; b <= len; b++) begin
      if (port == 1) begin
        check($sformatf("p1 rvalid[%0d]", b), 32'(bus.rvalid), 32'd1);
        check($sformatf("p1 rdata[%0d]", b), bus.rdata, exp[b]);
        check($sformatf("p1 rlast[%0d]", b), 32'(bus.rlast), 32'(b == len));
      end else begin
        check($sformatf("p2 rvalid[%0d]", b), 32'(bus.rvalid_2), 32'd1);
        check($sformatf("p2 rdata[%0d]", b), bus.rdata_2, exp[b]);
        check($sformatf("p2 rlast[%0d]", b), 32'(bus.rlast_2), 32'(b == len));
      end
      @(negedge clk);
    end
    if (port == 1) begin
      check("p1 rvalid end", 32'(bus.rvalid), 32'd0);
      check("p1 arready end", 32'(bus.arready), 32'd1);
    end else begin
      check("p2 rvalid end", 32'(bus.rvalid_2), 32'd0);
      check("p2 arready end", 32'(bus.arready_2), 32'd1);
    end
    bus.rready = 1'b0; bus.rready_2 = 1'b0;
  endtask

  // Full write burst of n beats, including the B handshake.
  task automatic write_burst(input int addr, input int n, input words_t d);
    $display("write addr %0d beats %0d", addr, n);
    @(negedge clk);
    check("w awready idle", 32'(bus.awready), 32'd1);
    bus.awaddr = 32'(addr); bus.awlen = 8'(n - 1); bus.awvalid = 1'b1;
    @(negedge clk);
    bus.awvalid = 1'b0;
    check("w awready busy", 32'(bus.awready), 32'd0);
    for (int b = 0; b < n; b++) begin
      check($sformatf("w wready[%0d]", b), 32'(bus.wready), 32'd1);
      bus.wdata = d[b]; bus.wvalid = 1'b1; bus.wlast = (b == n - 1);
      @(negedge clk);
    end
    bus.wvalid = 1'b0; bus.wlast = 1'b0;
    check("w bvalid", 32'(bus.bvalid), 32'd1);
    check("w bresp", 32'(bus.bresp), 32'd0);
    check("w wready after last", 32'(bus.wready), 32'd0);
    bus.bready = 1'b1;
    @(negedge clk);
    bus.bready = 1'b0;
    check("w bvalid cleared", 32'(bus.bvalid), 32'd0);
    check("w awready back", 32'(bus.awready), 32'd1);
  endtask

  int i1, i2;
  logic p1_rr;

  initial begin
    rst = 1'b1;
    idle_inputs();
    #12;
    check_reset_outputs("reset");
    @(negedge clk);
    rst = 1'b0;

    // init content readback
    exp_w = '{32'd5, 32'd6, 32'd7, 0, 0, 0, 0, 0};
    read_burst(1, 5, 2, exp_w);
    check("bresp idle", 32'(bus.bresp), 32'd0);

    // write four words at 0, read back on both ports
    exp_w = '{32'hA5A5A5A5, 32'h5A5A5A5A, 32'h12345678, 32'h87654321, 0, 0, 0, 0};
    write_burst(0, 4, exp_w);
    read_burst(1, 0, 3, exp_w);
    read_burst(2, 0, 3, exp_w);

    // concurrent bursts: port 1 at 8 len 2 with rready toggling, port 2 at 0 len 3
    $display("read  concurrent p1 addr 8 len 2 / p2 addr 0 len 3");
    @(negedge clk);
    bus.araddr = 32'd8; bus.arlen = 8'd2; bus.arvalid = 1'b1;
    bus.araddr_2 = 32'd0; bus.arlen_2 = 8'd3; bus.arvalid_2 = 1'b1; bus.rready_2 = 1'b1;
    @(negedge clk);
    bus.arvalid = 1'b0; bus.arvalid_2 = 1'b0;
    i1 = 0; i2 = 0;
    for (int cyc = 0; cyc < 8; cyc++) begin
      if (i1 <= 2) begin
        check($sformatf("cc p1 rvalid c%0d", cyc), 32'(bus.rvalid), 32'd1);
        check($sformatf("cc p1 rdata c%0d", cyc), bus.rdata, 32'(8 + i1));
        check($sformatf("cc p1 rlast c%0d", cyc), 32'(bus.rlast), 32'(i1 == 2));
      end else begin
        check($sformatf("cc p1 done c%0d", cyc), 32'(bus.rvalid), 32'd0);
      end
      if (i2 <= 3) begin
        check($sformatf("cc p2 rvalid c%0d", cyc), 32'(bus.rvalid_2), 32'd1);
        check($sformatf("cc p2 rdata c%0d", cyc), bus.rdata_2, exp_w[i2]);
        check($sformatf("cc p2 rlast c%0d", cyc), 32'(bus.rlast_2), 32'(i2 == 3));
      end else begin
        check($sformatf("cc p2 done c%0d", cyc), 32'(bus.rvalid_2), 32'd0);
      end
      p1_rr = (cyc % 2 == 0);
      bus.rready = p1_rr;
      @(negedge clk);
      if (p1_rr && i1 <= 2) i1++;
      if (i2 <= 3) i2++;
    end
    bus.rready = 1'b0; bus.rready_2 = 1'b0;

    // wrap-around write and read
    exp_w = '{32'd1, 32'd2, 32'd3, 32'd4, 0, 0, 0, 0};
    write_burst(30, 4, exp_w);
    read_burst(1, 30, 3, exp_w);

    // reset during the second write beat
    $display("write addr 10 aborted by reset on beat 2");
    @(negedge clk);
    bus.awaddr = 32'd10; bus.awlen = 8'd3; bus.awvalid = 1'b1;
    @(negedge clk);
    bus.awvalid = 1'b0;
    bus.wdata = 32'hDEAD0001; bus.wvalid = 1'b1;
    @(negedge clk);
    bus.wdata = 32'hDEAD0002;
    #2 rst = 1'b1;
    #1;
    check_reset_outputs("midrst");
    idle_inputs();
    @(negedge clk);
    rst = 1'b0;
    exp_w = '{32'd10, 0, 0, 0, 0, 0, 0, 0};
    read_burst(1, 10, 0, exp_w);
    exp_w = '{32'd0, 32'd1, 32'd2, 32'd3, 0, 0, 0, 0};
    read_burst(2, 0, 3, exp_w);
    exp_w = '{32'd30, 32'd31, 0, 0, 0, 0, 0, 0};
    read_burst(1, 30, 1, exp_w);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule

// File: doc/axi_memory_slave_3channels.md
# axi_memory_slave_3channels

Word-addressed on-chip memory slave with one AXI-style write port (AW/W/B) and two independent AXI-style read ports (AR/R and AR_2/R_2). Simplified AXI: INCR bursts only, no IDs, no strobes, always-OKAY response. Serves as the shared frame/line buffer between one producer block and two consumer blocks.

## Interface
- ADDR_WIDTH, 32, address bus width; address is a word index.
- DATA_WIDTH, 32, word width.
- ID_WIDTH, 4, kept for compatibility; no ID ports.
- MEM_SIZE, 32, depth in words; power of two.
- INIT_OPTION, 1, reset content: 0 = all zeros, 1 = mem[i] = i.

- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- awaddr  in  ADDR_WIDTH  burst start word address.
- awlen  in  8  beats minus 1.
- awvalid / awready  in / out  1  write-address handshake.
- wdata  in  DATA_WIDTH  write beat data.
- wlast  in  1  final write beat.
- wvalid / wready  in / out  1  write-data handshake.
- bresp  out  2  write response, always 2'b00.
- bvalid / bready  out / in  1  write-response handshake.
- araddr, arlen, arvalid / arready  in, in, in / out  ADDR_WIDTH, 8, 1 / 1  read port 1 address.
- rdata, rlast, rvalid / rready  out, out, out / in  DATA_WIDTH, 1, 1 / 1  read port 1 data.
- araddr_2, arlen_2, arvalid_2 / arready_2, rdata_2, rlast_2, rvalid_2 / rready_2  same as port 1, for read port 2.

## Operation
- Storage: MEM_SIZE x DATA_WIDTH words; index = addr[log2(MEM_SIZE)-1:0]; upper bits ignored.
- Write FSM: W_IDLE -> W_DATA -> W_RESP -> W_IDLE.
  - W_IDLE: awready=1. On awvalid: latch awaddr into internal pointer, go W_DATA.
  - W_DATA: wready=1. Each wvalid beat writes wdata to mem[ptr], ptr increments by 1. Beat with wlast=1 writes, then go W_RESP. awlen is latched but not used to end the burst; wlast alone terminates.
  - W_RESP: bvalid=1, bresp=00. On bready, go W_IDLE.
- Read FSM, one per port, identical and fully independent: R_IDLE -> R_DATA -> R_IDLE.
  - R_IDLE: arready=1. On arvalid: latch addr and len, load rdata <= mem[addr], beat counter = 0, go R_DATA.
  - R_DATA: rvalid=1. rlast=1 when counter == len. On rready: if rlast, go R_IDLE with rvalid=0. Otherwise counter++, ptr++, rdata <= mem[ptr+1].
  - Without rready, rdata, rlast and rvalid hold.
- Address pointers wrap modulo MEM_SIZE: 31 -> 0 for depth 32.
- Both read ports may run bursts concurrently with each other and with a write.
- Same-cycle write and read fetch of one word: the read gets the old content (read-before-write).
- Memory is reinitialized per INIT_OPTION on every reset.

## Timing
- Reset values: awready=1, arready=1, arready_2=1, wready=0, bvalid=0, bresp=00, rvalid/rvalid_2=0, rlast/rlast_2=0, rdata/rdata_2=0. All FSMs in IDLE. Reset asserted mid-burst aborts immediately, with no response issued.
- Ready signals are decoded from registered state.
- Write: AW handshake at edge N; wready=1 from N+1. One beat per cycle at full throughput. bvalid rises the cycle after the wlast beat is accepted. awready returns the cycle after the bready handshake.
- Read: AR handshake at edge N; rvalid and first rdata valid from N+1. One beat per cycle while rready=1. A burst of len+1 beats completes at N+len+1. arready returns the cycle after the last beat is accepted.
- Only handshakes sampled at a rising edge count.

## Test plan
- Reset with INIT_OPTION=1, then read port 1 burst at addr 5, len 2 -> rdata 5, 6, 7; rlast only on 7; bresp unaffected.
- AW addr 0, len 3; W beats A5A5A5A5, 5A5A5A5A, 12345678, 87654321 with wlast on the 4th -> bvalid one cycle later, bresp=00. Then port 1 read addr 0, len 3 -> same four words, rlast on 4th.
- Port 2 read addr 0, len 3 after the write above -> A5A5A5A5, 5A5A5A5A, 12345678, 87654321, rlast_2 on 4th.
- Ports 1 and 2 start a burst in the same cycle, with rready toggled 1/0 on port 1 -> each stream is correct; port 1 rdata holds while rready=0.
- Write at addr 30, 4 beats 1,2,3,4 -> mem[30]=1, mem[31]=2, mem[0]=3, mem[1]=4, confirmed by read wrap from addr 30.
- Assert rst during the 2nd write beat -> all outputs return to reset values; memory reads back per INIT_OPTION.
